// File: rtl/cofre_pkg.sv
// cofre_pkg: shared types and constants for the safe-lock controller.
//   estado_t    : controller state encoding
//   SEG_0..SEG_9: active-low seven-segment patterns {dp,g,f,e,d,c,b,a}
//   lock_cnt_w  : width of the lockout down-counter
//   seg7        : digit (0-9) to segment pattern; anything else blanks
package cofre_pkg;

    typedef enum logic [1:0] {
        ENTRADA   = 2'd0,
        COMPARA   = 2'd1,
        ABERTO    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic int lock_cnt_w(input int ciclos);
        return $clog2(ciclos + 1);
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/comparador_digito.sv
// comparador_digito: compares one entered digit against one stored digit.
//   a, b       : digits to compare
//   igual      : |a-b| == 0
//   dentro_tol : |a-b| <= TOLERANCE
module comparador_digito #(
    parameter int WIDTH     = 4,
    parameter int TOLERANCE = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             igual,
    output logic             dentro_tol
);

    logic [WIDTH:0]   sub;
    logic [WIDTH-1:0] dif;

    // One extra bit so the borrow tells us which operand was larger.
    assign sub        = {1'b0, a} - {1'b0, b};
    assign dif        = sub[WIDTH] ? WIDTH'(-sub) : sub[WIDTH-1:0];
    assign igual      = (dif == '0);
    assign dentro_tol = (32'(dif) <= 32'(TOLERANCE));

endmodule

// File: rtl/cofre_controlador.sv
// cofre_controlador: sequential safe-lock controller.
//   clk, reset_n      : clock, synchronous active-low reset
//   senha             : stored code, digit 0 in the MSB field
//   digito/_valido    : one entered digit per strobe
//   fechar            : relock request while open
//   led0/led1/led2    : open / near miss / wrong
//   bloqueado         : lockout in progress
//   display           : active-low attempts-left digit
// Build option: COFRE_DISPLAY_EN enables the seven-segment decoder;
// without it display is held at 8'hFF.
module cofre_controlador
    import cofre_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int DIGITS         = 4,
    parameter int TOLERANCE      = 3,
    parameter int MAX_TENTATIVAS = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DIGITS*WIDTH-1:0] senha,
    input  logic [WIDTH-1:0]        digito,
    input  logic                    digito_valido,
    input  logic                    fechar,
    output logic                    led0,
    output logic                    led1,
    output logic                    led2,
    output logic                    bloqueado,
    output logic [7:0]              display
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = lock_cnt_w(LOCKOUT_CYCLES);
    localparam logic [3:0] MAX_T = 4'(MAX_TENTATIVAS);
`ifdef COFRE_DISPLAY_EN
    localparam logic [7:0] DISP_RST = seg7(MAX_T);
`else
    localparam logic [7:0] DISP_RST = SEG_OFF;
`endif

    estado_t                        estado, estado_n;
    logic [IW-1:0]                  idx, idx_n;
    logic [DIGITS-1:0][WIDTH-1:0]   buffer, buffer_n;
    logic [3:0]                     falhas, falhas_n;
    logic [CW-1:0]                  cnt, cnt_n;
    logic                           led0_n, led1_n, led2_n, bloq_n;
    logic [7:0]                     display_n;

    logic [DIGITS-1:0]              igual, dentro_tol;
    logic                           todos_iguais, todos_tol;

    // buffer[i] holds entered digit i; stored digit i sits MSB-first in senha.
    for (genvar i = 0; i < DIGITS; i++) begin : g_cmp
        comparador_digito #(
            .WIDTH     (WIDTH),
            .TOLERANCE (TOLERANCE)
        ) u_cmp (
            .a          (buffer[i]),
            .b          (senha[(DIGITS-1-i)*WIDTH +: WIDTH]),
            .igual      (igual[i]),
            .dentro_tol (dentro_tol[i])
        );
    end

    assign todos_iguais = &igual;
    assign todos_tol    = &dentro_tol;

    always_comb begin
        estado_n = estado;
        idx_n    = idx;
        buffer_n = buffer;
        falhas_n = falhas;
        cnt_n    = cnt;
        led0_n   = led0;
        led1_n   = led1;
        led2_n   = led2;
        bloq_n   = bloqueado;
        case (estado)
            ENTRADA: begin
                if (digito_valido) begin
                    buffer_n[idx] = digito;
                    if (idx == '0) begin
                        led1_n = 1'b0;
                        led2_n = 1'b0;
                    end
                    if (idx == IW'(DIGITS - 1)) begin
                        idx_n    = '0;
                        estado_n = COMPARA;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            COMPARA: begin
                if (todos_iguais) begin
                    led0_n   = 1'b1;
                    falhas_n = '0;
                    estado_n = ABERTO;
                end else begin
                    if (todos_tol) led1_n = 1'b1;
                    else           led2_n = 1'b1;
                    falhas_n = falhas + 4'd1;
                    if (falhas_n == MAX_T) begin
                        estado_n = BLOQUEADO;
                        bloq_n   = 1'b1;
                        cnt_n    = CW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        estado_n = ENTRADA;
                    end
                end
            end
            ABERTO: begin
                // digito_valido is ignored here, so fechar always wins.
                if (fechar) begin
                    led0_n   = 1'b0;
                    estado_n = ENTRADA;
                end
            end
            BLOQUEADO: begin
                // Counter loaded with L-1 on entry: exit on the L-th edge.
                if (cnt == '0) begin
                    falhas_n = '0;
                    led1_n   = 1'b0;
                    led2_n   = 1'b0;
                    bloq_n   = 1'b0;
                    estado_n = ENTRADA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: estado_n = ENTRADA;
        endcase

        // Derived from next-state values so it moves with the fail counter.
`ifdef COFRE_DISPLAY_EN
        display_n = (estado_n == BLOQUEADO) ? SEG_0 : seg7(MAX_T - falhas_n);
`else
        display_n = SEG_OFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado    <= ENTRADA;
            idx       <= '0;
            buffer    <= '0;
            falhas    <= '0;
            cnt       <= '0;
            led0      <= 1'b0;
            led1      <= 1'b0;
            led2      <= 1'b0;
            bloqueado <= 1'b0;
            display   <= DISP_RST;
        end else begin
            estado    <= estado_n;
            idx       <= idx_n;
            buffer    <= buffer_n;
            falhas    <= falhas_n;
            cnt       <= cnt_n;
            led0      <= led0_n;
            led1      <= led1_n;
            led2      <= led2_n;
            bloqueado <= bloq_n;
            display   <= display_n;
        end
    end

endmodule

// File: tb/tb_cofre_controlador.sv
// tb_cofre_controlador: directed-vector bench for cofre_controlador
// (LOCKOUT_CYCLES=16, senha=16'h1234, other parameters at default).
module tb_cofre_controlador;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] senha;
    logic [3:0]  digito;
    logic        digito_valido;
    logic        fechar;
    logic        led0, led1, led2, bloqueado;
    logic [7:0]  display;

    int nvec = 0;
    int nerr = 0;

    cofre_controlador #(
        .WIDTH          (4),
        .DIGITS         (4),
        .TOLERANCE      (3),
        .MAX_TENTATIVAS (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .senha         (senha),
        .digito        (digito),
        .digito_valido (digito_valido),
        .fechar        (fechar),
        .led0          (led0),
        .led1          (led1),
        .led2          (led2),
        .bloqueado     (bloqueado),
        .display       (display)
    );

    always #5 clk = ~clk;

    // Hand-written active-low patterns for attempts-left digits.
    function automatic logic [7:0] disp(input int n);
`ifdef COFRE_DISPLAY_EN
        case (n)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            default: return 8'h00;
        endcase
`else
        return (n >= 0) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dig(input logic [3:0] d);
        digito        = d;
        digito_valido = 1'b1;
        tick();
        digito_valido = 1'b0;
    endtask

    // Enter four digits, then wait the COMPARA cycle so results are visible.
    task automatic code(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        dig(a); dig(b); dig(c); dig(d);
        tick();
    endtask

    task automatic relock();
        fechar = 1'b1;
        tick();
        fechar = 1'b0;
    endtask

    task automatic leds(input string tag, input logic o, input logic n,
                        input logic w, input logic b, input int left);
        chk({tag, ".led0"}, 32'(led0), 32'(o));
        chk({tag, ".led1"}, 32'(led1), 32'(n));
        chk({tag, ".led2"}, 32'(led2), 32'(w));
        chk({tag, ".bloq"}, 32'(bloqueado), 32'(b));
        chk({tag, ".disp"}, 32'(display), 32'(disp(left)));
    endtask

    initial begin
        int hi;
        reset_n       = 1'b0;
        senha         = 16'h1234;
        digito        = '0;
        digito_valido = 1'b0;
        fechar        = 1'b0;
        tick(); tick();
        leds("rst", 0, 0, 0, 0, 3);
        reset_n = 1'b1;

        // Correct code opens, relock closes.
        code(1, 2, 3, 4);
        leds("open", 1, 0, 0, 0, 3);
        relock();
        chk("close.led0", 32'(led0), 32'd0);

        // Near miss (diff 3), then wrong (diff 4).
        code(1, 2, 3, 7);
        leds("near", 0, 1, 0, 0, 2);
        dig(1);
        chk("firstdig.led1", 32'(led1), 32'd0);
        dig(2); dig(3); dig(8); tick();
        leds("wrong", 0, 0, 1, 0, 1);

        // Correct after two failures resets the count.
        code(1, 2, 3, 4);
        leds("reopen", 1, 0, 0, 0, 3);
        relock();

        // Three wrong attempts: only the third locks.
        code(9, 9, 9, 9);
        leds("w1", 0, 0, 1, 0, 2);
        code(9, 9, 9, 9);
        leds("w2", 0, 0, 1, 0, 1);
        code(9, 9, 9, 9);
        leds("w3", 0, 0, 1, 1, 0);

        // Lockout length, with digits strobed throughout.
        hi = 1;
        digito        = 4'd1;
        digito_valido = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bloqueado) break;
            hi++;
        end
        digito_valido = 1'b0;
        chk("lock.len", 32'(hi), 32'd16);
        leds("unlock", 0, 0, 0, 0, 3);
        code(1, 2, 3, 4);
        leds("postlock", 1, 0, 0, 0, 3);

        // fechar and digito_valido together: fechar wins, digit dropped.
        fechar        = 1'b1;
        digito        = 4'd1;
        digito_valido = 1'b1;
        tick();
        fechar        = 1'b0;
        digito_valido = 1'b0;
        chk("fech.led0", 32'(led0), 32'd0);
        code(2, 3, 4, 5);
        leds("fech.234", 0, 1, 0, 0, 2);
        code(1, 2, 3, 4);
        leds("fech.open", 1, 0, 0, 0, 3);
        relock();

        // Reset mid-entry clears leds, count and partial buffer.
        code(9, 9, 9, 9);
        leds("pre.rst", 0, 0, 1, 0, 2);
        dig(1); dig(2);
        reset_n = 1'b0;
        tick();
        leds("midrst", 0, 0, 0, 0, 3);
        reset_n = 1'b1;
        code(1, 2, 3, 4);
        leds("rst.open", 1, 0, 0, 0, 3);
        relock();

        // fechar in ENTRADA keeps the partial entry.
        dig(1); dig(2);
        relock();
        dig(3); dig(4); tick();
        leds("partial", 1, 0, 0, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cofre_controlador.md
# cofre_controlador

Sequential, parametrised safe-lock controller, the next-generation successor to the single-shot combinational lock. Accepts a multi-digit code one digit per handshake. Compares it against the stored code with a per-digit near-miss tolerance. Counts consecutive failures and enforces a timed lockout. Drives the open/near/wrong LEDs and a seven-segment attempts display.

## Interface
- `WIDTH`, 4: bits per digit.
- `DIGITS`, 4: digits per code.
- `TOLERANCE`, 3: maximum per-digit absolute difference that counts as a near miss.
- `MAX_TENTATIVAS`, 3: consecutive failures before lockout; legal range 1..9.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clock cycles; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `senha` in DIGITS*WIDTH: stored code; digit 0 is the MSB field; sampled in COMPARA.
- `digito` in WIDTH: entered digit.
- `digito_valido` in 1: digit strobe; one digit is captured per high cycle.
- `fechar` in 1: relock request.
- `led0` out 1: safe open.
- `led1` out 1: last attempt was a near miss.
- `led2` out 1: last attempt was wrong (not a near miss).
- `bloqueado` out 1: lockout active.
- `display` out 8: active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- States: ENTRADA, COMPARA, ABERTO, BLOQUEADO.
- Reset values: state=ENTRADA, digit index=0, buffer=0, fail count=0, led0/led1/led2/bloqueado=0, display shows MAX_TENTATIVAS.
- ENTRADA:
  - `digito_valido` stores `digito` at the current index and increments the index.
  - The first digit of a new attempt clears led1/led2.
  - When the DIGITS-th digit is captured, the index returns to 0 and the state goes to COMPARA.
- COMPARA (1 cycle), per digit: |a−b| computed with WIDTH+1-bit subtraction.
  - All differences 0: led0=1, fail count=0, state goes to ABERTO.
  - All differences ≤ TOLERANCE, at least one nonzero: led1=1 and the fail count increments.
  - Otherwise: led2=1 and the fail count increments.
  - If the incremented count reaches MAX_TENTATIVAS, the state goes to BLOQUEADO; otherwise it goes to ENTRADA.
- ABERTO:
  - `digito_valido` is ignored.
  - `fechar` clears led0 and returns the state to ENTRADA.
  - If `fechar` and `digito_valido` occur in the same cycle, `fechar` wins and the digit is discarded.
- BLOQUEADO:
  - bloqueado=1; all inputs except reset are ignored; a down-counter loads LOCKOUT_CYCLES−1.
  - When the counter reaches 0: fail count=0, led1/led2 cleared, bloqueado=0, state goes to ENTRADA.
  - led1/led2 from the final failed attempt stay visible during the lockout.
- `fechar` in ENTRADA is ignored; a partial entry is kept.
- Reset asserted mid-entry or mid-lockout returns every register to its reset value.
- Display shows MAX_TENTATIVAS − fail count as a digit 0–9; it shows 0 while BLOQUEADO.

## Timing
- Digit capture: at the clock edge where `digito_valido`=1.
- Result latency:
  - Last digit at edge N; COMPARA during cycle N..N+1; LEDs/bloqueado registered at edge N+1, visible after it.
- All outputs are registered; there are no combinational paths from input to output.
- `bloqueado` is high for exactly LOCKOUT_CYCLES cycles.
- ENTRADA accepts digits on the first cycle after bloqueado falls.
- The display updates in the same cycle as the fail-count register.

## Configuration
- `COFRE_DISPLAY_EN` defined: seven-segment decoder is present; `display` behaves as described above.
- Not defined: decoder is removed and `display` is tied to 8'hFF (all segments off); all other behaviour is unchanged.

## Structure
- Package `cofre_pkg`:
  - State enum.
  - Seven-segment constants for 0–9.
  - Function for the lockout-counter width ($clog2(LOCKOUT_CYCLES+1)).
- Sub-module `comparador_digito`:
  - Per-digit absolute difference, plus `igual` and `dentro_tol` flags.
  - Instantiated DIGITS times via generate.
  - The top level ANDs the flags across digits.

## Test plan
Defaults, with LOCKOUT_CYCLES=16 and senha=16'h1234.
- Enter 1,2,3,4: led0=1 one edge after the last digit; led1=led2=0; display shows "3".
- Enter 1,2,3,7: led1=1, led2=0; display shows "2". Next, enter 1,2,3,8: led2=1, led1=0; display shows "1".
- Three attempts of 9,9,9,9: bloqueado=1 for exactly 16 cycles; digits strobed during lockout are ignored; display shows "0". Then 1,2,3,4 opens the safe.
- Enter 1,2; pulse reset_n low for 1 cycle; enter 1,2,3,4: opens (buffer was cleared). All outputs are at reset values during reset.
- In ABERTO, assert `fechar` and `digito_valido` with digito=1 in the same cycle: led0=0 and the state is ENTRADA. The following 2,3,4 must not open the safe; a fresh 1,2,3,4 must open it.
- Two failures, then a correct code: fail count resets, display shows "3", and a later single failure does not lock.
